router_src_arbiter: RTL

- Packet-granular round-robin arbiter that shares the router's single input port (pkt_valid, data_in, busy) among three packet sources.
- Sits between the source interfaces and the router top. Grants one whole packet at a time: header, payload, then parity.
- Muxes the granted source onto the router and returns router backpressure only to that source.
- Checks header length against the payload count and screens invalid destination addresses.

---
 rtl/router_src_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/router_src_arbiter.sv
// Packet-granular round-robin arbiter sharing the router input port among three sources.
// One whole packet (header, payload, parity) is passed before the grant can move.
module router_src_arbiter #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [2:0]            src_pkt_valid,
  input  logic [3*DATA_W-1:0]   src_data,
  output logic [2:0]            src_busy,
  output logic [2:0]            src_gnt,
  input  logic                  rtr_busy,
  input  logic                  rtr_detect_add,
  output logic                  rtr_pkt_valid,
  output logic [DATA_W-1:0]     rtr_data,
  output logic                  len_err,
  output logic [2:0]            addr_err,
  output logic                  pkt_done
);

  localparam int NUM_SRC = 3;

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t                          state_q, state_d;
  logic [NUM_SRC-1:0]              gnt_q, gnt_d;
  logic [1:0]                      last_q, last_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [LEN_W-1:0]                cnt_q, cnt_d;
  logic                            hdr_q, hdr_d;

  logic [NUM_SRC-1:0][DATA_W-1:0]  sd;
  logic [NUM_SRC-1:0]              req;
  logic                            idle, pass, xfer;
  logic                            g_valid;
  logic [DATA_W-1:0]               g_data;
  logic [1:0]                      pick;
  logic                            done_c, lerr_c;

  assign sd = src_data;

  // Outputs are gated by resetn so nothing leaks while reset is held.
  assign idle = resetn && (state_q == IDLE);
  assign pass = resetn && (state_q == PASS);

  // last_q always names the granted source while a packet is in flight.
  assign g_valid = src_pkt_valid[last_q];
  assign g_data  = sd[last_q];
  assign xfer    = pass && !rtr_busy;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_lane
    logic bad_addr;
    assign bad_addr    = (sd[k][1:0] == 2'd3);
    assign req[k]      = idle && src_pkt_valid[k] && !bad_addr;
    assign addr_err[k] = idle && src_pkt_valid[k] && bad_addr;
    assign src_busy[k] = (pass && gnt_q[k]) ? rtr_busy : 1'b1;
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    int   start;
    int   idx;
    logic found;
    pick  = 2'd0;
    found = 1'b0;
    start = (last_q == 2'd2) ? 0 : int'(last_q) + 1;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = start + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = 2'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    done_c  = 1'b0;
    lerr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = PASS;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          last_d      = pick;
          hdr_d       = 1'b1;
        end
      end
      PASS: begin
        if (xfer) begin
          if (hdr_q) begin
            len_d = g_data[2 +: LEN_W];
            cnt_d = '0;
            hdr_d = 1'b0;
          end else if (g_valid) begin
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          end else begin
            done_c  = 1'b1;
            lerr_c  = (cnt_q != len_q);
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Hold the grant until the router is back in address decode.
        if (rtr_detect_add) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 2'd2;
      len_q   <= '0;
      cnt_q   <= '0;
      hdr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
    end
  end

  assign src_gnt       = gnt_q;
  assign rtr_pkt_valid = pass && g_valid;
  assign rtr_data      = pass ? g_data : '0;
  assign pkt_done      = done_c;
  assign len_err       = lerr_c;

endmodule
